// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: rebuilds row/col/displayEnable from hsync_n/vsync_n and checks line/frame timing.
// Latency: internal counters trail the source by 2 clocks; all outputs are registered, 3 clocks in total.
// Backpressure: none; the sync stream is consumed every clock and cannot be stalled.
//
// Ports:
//   clockVGA, reset_n        pixel clock, asynchronous active-low reset
//   hsync_n, vsync_n         incoming active-low syncs (same clock domain as clockVGA)
//   displayEnable, row, col  regenerated visible-window position (0 outside window or when unlocked)
//   frameStart               one-cycle pulse per accepted vsync falling edge
//   lineError, frameError    one-cycle pulses on horizontal / vertical timing violations
//   locked                   high while the lock FSM is in LOCKED
module vga_sync_decoder #(
   parameter int displayWidth  = 640,
   parameter int displayHeight = 480,
   parameter int hsyncTime     = 96,
   parameter int hBPTime       = 48,
   parameter int hFPTime       = 16,
   parameter int vsyncTime     = 2,
   parameter int vBPTime       = 33,
   parameter int vFPTime       = 10,
   parameter int lockFrames    = 2
) (
   input  logic       clockVGA,
   input  logic       reset_n,
   input  logic       hsync_n,
   input  logic       vsync_n,
   output logic       displayEnable,
   output logic [9:0] row,
   output logic [9:0] col,
   output logic       frameStart,
   output logic       lineError,
   output logic       frameError,
   output logic       locked
);

   localparam int hTotal = hsyncTime + hBPTime + displayWidth + hFPTime;
   localparam int vTotal = vsyncTime + vBPTime + displayHeight + vFPTime;

   localparam logic [9:0] hSyncLast = 10'(hsyncTime - 1);
   localparam logic [9:0] hLast     = 10'(hTotal - 1);
   localparam logic [9:0] vLast     = 10'(vTotal - 1);
   localparam logic [9:0] vSyncEnd  = 10'(vsyncTime);
   localparam logic [9:0] hVisStart = 10'(hsyncTime + hBPTime);
   localparam logic [9:0] hVisEnd   = 10'(hsyncTime + hBPTime + displayWidth);
   localparam logic [9:0] vVisStart = 10'(vsyncTime + vBPTime);
   localparam logic [9:0] vVisEnd   = 10'(vsyncTime + vBPTime + displayHeight);
   localparam logic [3:0] lockTarget = 4'(lockFrames);

   typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} lockState_e;

   logic       hD1, hD2, vD1, vD2;
   logic       hFall, hRise, vFall, vRise;
   logic [9:0] hCount, vCount, vLineNow;
   lockState_e state, stateNext;
   logic [3:0] goodCount, goodNext, goodInc;
   logic       hFirst, vFirst, frameDirty;
   logic       searching, timeoutNow, lineErrNow, frameErrNow, anyErr;
   logic       showPixel;

   // Two-stage sample; edges are judged between the two stages.
   always_ff @(posedge clockVGA or negedge reset_n) begin
      if (!reset_n) begin
         hD1 <= 1'b1;
         hD2 <= 1'b1;
         vD1 <= 1'b1;
         vD2 <= 1'b1;
      end else begin
         hD1 <= hsync_n;
         hD2 <= hD1;
         vD1 <= vsync_n;
         vD2 <= vD1;
      end
   end

   assign hFall = hD2 & ~hD1;
   assign hRise = ~hD2 & hD1;
   assign vFall = vD2 & ~vD1;
   assign vRise = ~vD2 & vD1;

   assign searching = (state == SEARCH);
   // Line the vertical counter is entering this cycle; a vsync rise is
   // legal only when it coincides with the start of line vsyncTime.
   assign vLineNow  = hFall ? vCount + 10'd1 : vCount;

   // Timeout fires on the single clock where hCount steps onto its saturation value.
   assign timeoutNow = (hCount == 10'd1022) && !hFall;

   assign lineErrNow = timeoutNow
                     | (!searching && hRise && (hCount != hSyncLast))
                     | (!searching && hFall && !hFirst && (hCount != hLast));

   assign frameErrNow = !searching && ((vFall && !hFall)
                                     | (vFall && !vFirst && (vCount != vLast))
                                     | (vRise && (vLineNow != vSyncEnd)));

   assign anyErr  = lineErrNow | frameErrNow;
   assign goodInc = goodCount + 4'd1;

   always_ff @(posedge clockVGA or negedge reset_n) begin
      if (!reset_n) begin
         hCount <= '0;
         vCount <= '0;
      end else begin
         if (hFall)
            hCount <= '0;
         else if (hCount != 10'd1023)
            hCount <= hCount + 10'd1;

         if (vFall)
            vCount <= '0;
         else if (hFall && (vCount != 10'd1023))
            vCount <= vCount + 10'd1;
      end
   end

   always_comb begin
      stateNext = state;
      goodNext  = goodCount;
      case (state)
         SEARCH: begin
            if (vFall) begin
               stateNext = ACQUIRE;
               goodNext  = '0;
            end
         end
         ACQUIRE: begin
            if (anyErr)
               goodNext = '0;
            else if (vFall) begin
               // A frame that saw any error earlier does not count toward lock.
               if (frameDirty)
                  goodNext = '0;
               else begin
                  goodNext = goodInc;
                  if (goodInc >= lockTarget)
                     stateNext = LOCKED;
               end
            end
         end
         LOCKED: begin
            if (anyErr) begin
               stateNext = ACQUIRE;
               goodNext  = '0;
            end
         end
         default: stateNext = SEARCH;
      endcase
      if (timeoutNow) begin
         stateNext = SEARCH;
         goodNext  = '0;
      end
   end

   always_ff @(posedge clockVGA or negedge reset_n) begin
      if (!reset_n) begin
         state      <= SEARCH;
         goodCount  <= '0;
         hFirst     <= 1'b1;
         vFirst     <= 1'b1;
         frameDirty <= 1'b0;
      end else begin
         state     <= stateNext;
         goodCount <= goodNext;
         if (searching) begin
            // Counters are not yet aligned to the source, so the first
            // period check after leaving SEARCH is skipped.
            hFirst     <= 1'b1;
            vFirst     <= 1'b1;
            frameDirty <= 1'b0;
         end else begin
            if (hFall) hFirst <= 1'b0;
            if (vFall) vFirst <= 1'b0;
            frameDirty <= vFall ? 1'b0 : (frameDirty | anyErr);
         end
      end
   end

   assign showPixel = (state == LOCKED)
                    && (hCount >= hVisStart) && (hCount < hVisEnd)
                    && (vCount >= vVisStart) && (vCount < vVisEnd);

   always_ff @(posedge clockVGA or negedge reset_n) begin
      if (!reset_n) begin
         displayEnable <= 1'b0;
         row           <= '0;
         col           <= '0;
         frameStart    <= 1'b0;
         lineError     <= 1'b0;
         frameError    <= 1'b0;
      end else begin
         displayEnable <= showPixel;
         col           <= showPixel ? hCount - hVisStart : '0;
         row           <= showPixel ? vCount - vVisStart : '0;
         frameStart    <= vFall & (searching | hFall);
         lineError     <= lineErrNow;
         frameError    <= frameErrNow;
      end
   end

   assign locked = (state == LOCKED);

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: drives a scaled-down sync stream and scoreboards the decoder's output events.
// Latency: expected events are scheduled 2 (pulses, lock) or 3 (displayEnable) clocks after the stimulus sample.
// Backpressure: none; the monitor consumes one output event at a time in (cycle, kind) order.
module tb_vga_sync_decoder;

   localparam int W   = 16;
   localparam int H   = 6;
   localparam int HS  = 4;
   localparam int HBP = 6;
   localparam int HFP = 4;
   localparam int VS  = 2;
   localparam int VBP = 3;
   localparam int VFP = 2;
   localparam int HT  = HS + HBP + W + HFP;   // 30 clocks per line
   localparam int VT  = VS + VBP + H + VFP;   // 13 lines per frame
   localparam int HV0 = HS + HBP;             // first visible column in source counts
   localparam int VV0 = VS + VBP;             // first visible line in source counts

   localparam int EV_FS     = 0;
   localparam int EV_LERR   = 1;
   localparam int EV_FERR   = 2;
   localparam int EV_LRISE  = 3;
   localparam int EV_LFALL  = 4;
   localparam int EV_DERISE = 5;
   localparam int EV_DEFALL = 6;

   typedef struct {
      int kind;
      int cycle;
      int r;
      int c;
   } evT;

   evT expQ[$];

   logic       clockVGA = 1'b0;
   logic       reset_n  = 1'b0;
   logic       hsync_n  = 1'b1;
   logic       vsync_n  = 1'b1;
   logic       displayEnable;
   logic [9:0] row, col;
   logic       frameStart, lineError, frameError, locked;

   int cyc = 0;
   int total = 0;
   int bad = 0;
   bit stimDone = 1'b0;

   vga_sync_decoder #(
      .displayWidth(W), .displayHeight(H),
      .hsyncTime(HS), .hBPTime(HBP), .hFPTime(HFP),
      .vsyncTime(VS), .vBPTime(VBP), .vFPTime(VFP),
      .lockFrames(2)
   ) dut (
      .clockVGA(clockVGA), .reset_n(reset_n),
      .hsync_n(hsync_n), .vsync_n(vsync_n),
      .displayEnable(displayEnable), .row(row), .col(col),
      .frameStart(frameStart), .lineError(lineError), .frameError(frameError),
      .locked(locked)
   );

   always #5 clockVGA = ~clockVGA;
   always @(posedge clockVGA) cyc <= cyc + 1;

   // Keep the expected queue ordered by cycle, then by kind, matching the monitor's scan order.
   function automatic void pushExp(int k, int cy, int r, int c);
      evT e;
      int i;
      e.kind = k; e.cycle = cy; e.r = r; e.c = c;
      i = expQ.size();
      while (i > 0 && (expQ[i-1].cycle > cy || (expQ[i-1].cycle == cy && expQ[i-1].kind > k)))
         i--;
      expQ.insert(i, e);
   endfunction

   task automatic check(string name, int act, int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (cyc %0d)", name, act, req, cyc);
      end
   endtask

   task automatic popCheck(int k, int r, int c);
      evT e;
      total++;
      if (expQ.size() == 0) begin
         bad++;
         $display("FAIL unexpected_event: got kind=%0d cyc=%0d row=%0d col=%0d want none", k, cyc, r, c);
      end else begin
         e = expQ.pop_front();
         if (e.kind != k || e.cycle != cyc || e.r != r || e.c != c) begin
            bad++;
            $display("FAIL event: got kind=%0d cyc=%0d row=%0d col=%0d want kind=%0d cyc=%0d row=%0d col=%0d",
                     k, cyc, r, c, e.kind, e.cycle, e.r, e.c);
         end
      end
   endtask

   // Monitor: turns DUT output activity into events and compares each against the scoreboard.
   initial begin : monitor
      logic prevDe, prevLocked;
      int   prevRow, prevCol, doneCount;
      prevDe = 1'b0; prevLocked = 1'b0; prevRow = 0; prevCol = 0; doneCount = 0;
      forever begin
         @(negedge clockVGA or negedge reset_n);
         if (!reset_n) begin
            #1;
            check("rst_de",         int'(displayEnable), 0);
            check("rst_row",        int'(row), 0);
            check("rst_col",        int'(col), 0);
            check("rst_frameStart", int'(frameStart), 0);
            check("rst_lineError",  int'(lineError), 0);
            check("rst_frameError", int'(frameError), 0);
            check("rst_locked",     int'(locked), 0);
            prevDe = 1'b0; prevLocked = 1'b0;
         end else begin
            if (frameStart)               popCheck(EV_FS, 0, 0);
            if (lineError)                popCheck(EV_LERR, 0, 0);
            if (frameError)               popCheck(EV_FERR, 0, 0);
            if (locked && !prevLocked)    popCheck(EV_LRISE, 0, 0);
            if (!locked && prevLocked)    popCheck(EV_LFALL, 0, 0);
            if (displayEnable && !prevDe) popCheck(EV_DERISE, int'(row), int'(col));
            if (!displayEnable && prevDe) popCheck(EV_DEFALL, prevRow, prevCol);
            if (!displayEnable)           check("idle_rowcol", int'(row) + int'(col), 0);
            prevDe = displayEnable; prevLocked = locked;
            prevRow = int'(row); prevCol = int'(col);
         end
         if (stimDone) begin
            doneCount++;
            if (doneCount == 8) begin
               check("leftover_expected", expQ.size(), 0);
               foreach (expQ[i])
                  $display("FAIL missing_event: kind=%0d cyc=%0d row=%0d col=%0d", expQ[i].kind, expQ[i].cycle, expQ[i].r, expQ[i].c);
               $display("test done: total=%0d bad=%0d", total, bad);
               $finish;
            end
         end
      end
   end

   // One source sample per clock, the way a registered VGA generator would present it.
   task automatic drive(int hc, int vc, int hsW);
      hsync_n = (hc < hsW) ? 1'b0 : 1'b1;
      vsync_n = (vc < VS)  ? 1'b0 : 1'b1;
      @(posedge clockVGA); #1;
   endtask

   task automatic runLine(int vc, int hc0, int hc1, int hsW, bit deOn);
      for (int hc = hc0; hc < hc1; hc++) begin
         if (deOn && vc >= VV0 && vc < VV0 + H) begin
            if (hc == HV0)     pushExp(EV_DERISE, cyc + 3, vc - VV0, 0);
            if (hc == HV0 + W) pushExp(EV_DEFALL, cyc + 3, vc - VV0, W - 1);
         end
         drive(hc, vc, hsW);
      end
   endtask

   task automatic runFrame(bit deOn, bit fs, bit lockRise);
      if (fs)       pushExp(EV_FS, cyc + 2, 0, 0);
      if (lockRise) pushExp(EV_LRISE, cyc + 2, 0, 0);
      for (int vc = 0; vc < VT; vc++) runLine(vc, 0, HT, HS, deOn);
   endtask

   initial begin : stimulus
      int holdStart;
      repeat (3) @(posedge clockVGA);
      #1;
      reset_n = 1'b1;

      // Nominal acquisition: join mid-frame, lock one cycle after the third vsync fall.
      for (int vc = 4; vc < VT; vc++) runLine(vc, 0, HT, HS, 1'b0);
      runFrame(1'b0, 1'b1, 1'b0);
      runFrame(1'b0, 1'b1, 1'b0);
      runFrame(1'b1, 1'b1, 1'b1);
      runFrame(1'b1, 1'b1, 1'b0);

      // One line one clock short: single lineError, lock lost, relock after two clean frames.
      pushExp(EV_FS, cyc + 2, 0, 0);
      for (int vc = 0; vc < VT; vc++) begin
         if (vc == 8) begin
            pushExp(EV_LERR,  cyc + 2, 0, 0);
            pushExp(EV_LFALL, cyc + 2, 0, 0);
         end
         runLine(vc, 0, (vc == 7) ? HT - 1 : HT, HS, vc < 8);
      end
      runFrame(1'b0, 1'b1, 1'b0);
      runFrame(1'b0, 1'b1, 1'b0);
      runFrame(1'b1, 1'b1, 1'b1);

      // hsync pulse one clock narrow: lineError at the rising edge.
      pushExp(EV_FS, cyc + 2, 0, 0);
      for (int vc = 0; vc < VT; vc++) begin
         if (vc == 6) begin
            pushExp(EV_LERR,  cyc + HS - 1 + 2, 0, 0);
            pushExp(EV_LFALL, cyc + HS - 1 + 2, 0, 0);
         end
         runLine(vc, 0, HT, (vc == 6) ? HS - 1 : HS, vc < 6);
      end
      // Frame one line short: frameError at the following vsync fall.
      pushExp(EV_FS, cyc + 2, 0, 0);
      for (int vc = 0; vc < VT - 1; vc++) runLine(vc, 0, HT, HS, 1'b0);
      pushExp(EV_FERR, cyc + 2, 0, 0);
      runFrame(1'b0, 1'b1, 1'b0);
      runFrame(1'b0, 1'b1, 1'b0);
      runFrame(1'b1, 1'b1, 1'b1);

      // Syncs stuck high: one lineError when hCount saturates, lock dropped.
      holdStart = cyc - HT;   // sample carrying the last hsync fall
      pushExp(EV_LERR,  holdStart + 1025, 0, 0);
      pushExp(EV_LFALL, holdStart + 1025, 0, 0);
      for (int i = 0; i < 1100; i++) drive(HT - 1, VT - 1, HS);
      runFrame(1'b0, 1'b1, 1'b0);
      runFrame(1'b0, 1'b1, 1'b0);
      pushExp(EV_FS,    cyc + 2, 0, 0);
      pushExp(EV_LRISE, cyc + 2, 0, 0);
      for (int vc = 0; vc < 7; vc++) runLine(vc, 0, HT, HS, 1'b1);
      runLine(7, 0, 15, HS, 1'b1);

      // Reset mid-line while displaying: everything clears at once, relock as from power-up.
      reset_n = 1'b0;
      repeat (2) begin
         @(posedge clockVGA); #1;
      end
      reset_n = 1'b1;
      runLine(7, 15, HT, HS, 1'b0);
      for (int vc = 8; vc < VT; vc++) runLine(vc, 0, HT, HS, 1'b0);
      runFrame(1'b0, 1'b1, 1'b0);
      runFrame(1'b0, 1'b1, 1'b0);
      runFrame(1'b1, 1'b1, 1'b1);

      stimDone = 1'b1;
      repeat (100) @(posedge clockVGA);
      $display("FAIL watchdog: monitor did not reach summary");
      $fatal(1);
   end

endmodule
